// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder.
//   - Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
//   - SEG_BLANK: all segments off
//   - seg7_state_e: debounce FSM state encoding
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational 7-segment pattern decoder.
//   pat_i    [6:0] active-low segments {g,f,e,d,c,b,a}
//   hit_o          pattern is one of the 16 hex glyphs
//   blank_o        pattern is all-off and blank support is built in
//   nibble_o [3:0] decoded value (0 when hit_o is low)
// Build option: SEG7_DEC_BLANK_EN reports the all-off pattern as blank
// instead of leaving it an undecodable pattern.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       hit_o,
  output logic       blank_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    hit_o    = 1'b1;
    nibble_o = 4'h0;
    case (pat_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: hit_o    = 1'b0;
    endcase
  end

`ifdef SEG7_DEC_BLANK_EN
  assign blank_o = (pat_i == SEG_BLANK);
`else
  assign blank_o = 1'b0;
`endif

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive end of a multiplexed 7-segment bus: synchronizes the scanned
// segment/anode lines, debounces each digit slot and keeps a decoded
// per-digit register file.
//   clk, rst_n    clock, asynchronous active-low reset
//   hex   [6:0]   segments {g..a}, active-low, asynchronous
//   AN    [N-1:0] anodes, active-low, asynchronous
//   clr           synchronous clear of digits/valid/err
//   digits[4N-1:0] decoded nibbles, digit i at [4i+3:4i]
//   valid [N-1:0] digit holds a decoded value
//   err   [N-1:0] sticky undecodable-pattern flag
//   upd, upd_idx  one-cycle accept pulse and the accepted digit index
//   dbg_state_o   current debounce FSM state (seg7_state_e encoding)
// Build option: SEG7_DEC_BLANK_EN (see seg7_pattern_dec).
//
// Accept timing: a sample must be seen STABLE_CNT times in a row (the counter
// tracks repeats of s against the previous sample p); the register file and
// upd update on the edge after the last matching sample.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CNT = 4,
  localparam int IDXW = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              hex,
  input  logic [NUM_DIGITS-1:0]   AN,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    upd,
  output logic [IDXW-1:0]         upd_idx,
  output logic [1:0]              dbg_state_o
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

  // Synchronizers and previous-sample register; reset to the idle bus (all off)
  logic [6:0]            hex_s1_q, hex_s2_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;
  logic [SW-1:0]         p_q;
  logic [SW-1:0]         s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_s1_q <= '1;
      hex_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      p_q      <= '1;
    end else begin
      hex_s1_q <= hex;
      hex_s2_q <= hex_s1_q;
      an_s1_q  <= AN;
      an_s2_q  <= an_s1_q;
      p_q      <= s;
    end
  end

  assign s = {an_s2_q, hex_s2_q};

  // A sample qualifies only when exactly one anode is driven low
  logic            qual;
  logic [IDXW-1:0] idx;
  int              n_low;

  always_comb begin
    n_low = 0;
    idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2_q[i]) begin
        n_low = n_low + 1;
        idx   = IDXW'(i);
      end
    end
    qual = (n_low == 1);
  end

  logic       dec_hit, dec_blank;
  logic [3:0] dec_nib;

  seg7_pattern_dec u_dec (
    .pat_i    (hex_s2_q),
    .hit_o    (dec_hit),
    .blank_o  (dec_blank),
    .nibble_o (dec_nib)
  );

  // Debounce FSM
  seg7_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (qual) begin
          state_d = ST_TRACK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_TRACK: begin
        if (!qual) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (s == p_q) begin
          if (cnt_q == CNT_ACC) begin
            accept  = 1'b1;
            state_d = ST_HELD;
          end
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = CNT_ONE;
        end
      end
      ST_HELD: begin
        // An unchanged pattern never re-triggers an accept
        if (s != p_q) begin
          if (qual) begin
            state_d = ST_TRACK;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register file; clr applies first so a same-cycle accept keeps its digit
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, err_q, err_d;
  logic                    upd_q, upd_d;
  logic [IDXW-1:0]         upd_idx_q, upd_idx_d;

  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    err_d     = err_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    if (clr) begin
      digits_d = '0;
      valid_d  = '0;
      err_d    = '0;
    end
    if (accept) begin
      upd_d     = 1'b1;
      upd_idx_d = idx;
      if (dec_blank) begin
        valid_d[idx] = 1'b0;
      end else if (dec_hit) begin
        digits_d[4*idx +: 4] = dec_nib;
        valid_d[idx]         = 1'b1;
      end else begin
        valid_d[idx] = 1'b0;
        err_d[idx]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q  <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
    end
  end

  assign digits      = digits_q;
  assign valid       = valid_q;
  assign err         = err_q;
  assign upd         = upd_q;
  assign upd_idx     = upd_idx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Loopback bench for seg7_scan_decoder (NUM_DIGITS=8, STABLE_CNT=4).
// Honours SEG7_DEC_BLANK_EN for the blank-pattern expectations.
module tb_seg7_scan_decoder;

  localparam int SB_W = 9; // {idx[2:0], nibble[3:0], valid, err}
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  hex_r;
  logic [7:0]  an_r;
  logic        clr;
  logic [31:0] digits;
  logic [7:0]  valid, err;
  logic        upd;
  logic [2:0]  upd_idx;
  logic [1:0]  dbg_state;

  seg7_scan_decoder #(.NUM_DIGITS(8), .STABLE_CNT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hex         (hex_r),
    .AN          (an_r),
    .clr         (clr),
    .digits      (digits),
    .valid       (valid),
    .err         (err),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] sb_exp, sb_got;
  int n_vec = 0;
  int n_err = 0;

  logic [3:0] m_dig [8];
  logic [7:0] m_val, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_digits();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = m_dig[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
    m_val = '0;
    m_err = '0;
  endtask

  // Predict the outcome of accepting pattern pat on digit idx
  task automatic push_acc(input int idx, input logic [6:0] pat);
    logic hit, blank;
    logic [3:0] nib;
    hit = 1'b0;
    nib = 4'h0;
    blank = 1'b0;
    for (int v = 0; v < 16; v++) begin
      if (SEG_TAB[v] == pat) begin
        hit = 1'b1;
        nib = 4'(v);
      end
    end
`ifdef SEG7_DEC_BLANK_EN
    blank = (pat == 7'b1111111);
`endif
    if (blank) begin
      m_val[idx] = 1'b0;
    end else if (hit) begin
      m_dig[idx] = nib;
      m_val[idx] = 1'b1;
    end else begin
      m_val[idx] = 1'b0;
      m_err[idx] = 1'b1;
    end
    exp_q.push_back({3'(idx), m_dig[idx], m_val[idx], m_err[idx]});
  endtask

  // driver: call at posedge+1; bus held for n sampling edges
  task automatic hold(input logic [7:0] an, input logic [6:0] hx, input int n);
    an_r  = an;
    hex_r = hx;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_digits"}, digits, m_digits());
    check({tag, "_valid"}, {24'b0, valid}, {24'b0, m_val});
    check({tag, "_err"}, {24'b0, err}, {24'b0, m_err});
  endtask

  // monitor: every upd pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && upd) begin
      if (exp_q.size() == 0) begin
        check("upd_spurious", {31'b0, upd}, 32'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        sb_got = {upd_idx, digits[4*upd_idx +: 4], valid[upd_idx], err[upd_idx]};
        check("upd_result", {23'b0, sb_got}, {23'b0, sb_exp});
      end
    end
  end

  int lat;
  int prev_idx, r_idx, r_val, r_len;

  initial begin
    rst_n = 1'b0;
    an_r  = '1;
    hex_r = '1;
    clr   = 1'b0;
    model_clear();

    // reset state
    #12;
    check("rst_digits", digits, 32'd0);
    check("rst_valid", {24'b0, valid}, 32'd0);
    check("rst_err", {24'b0, err}, 32'd0);
    check("rst_upd", {31'b0, upd}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    hold(8'hFF, 7'h7F, 4);

    // single digit 3 on anode 0, with latency measurement
    push_acc(0, SEG_TAB[3]);
    an_r  = 8'hFE;
    hex_r = SEG_TAB[3];
    lat   = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (upd && lat == 0) lat = k;
    end
    check("latency", lat, 32'd6);
    hold(8'hFF, 7'h7F, 5);
    check("t2_digit0", {28'b0, digits[3:0]}, 32'd3);
    check("t2_valid", {24'b0, valid}, 32'h01);

    // full scan F..8 on digits 7..0
    for (int i = 7; i >= 0; i--) begin
      push_acc(i, SEG_TAB[8 + i]);
      hold(~(8'h01 << i), SEG_TAB[8 + i], 8);
    end
    hold(8'hFF, 7'h7F, 10);
    check("t3_digits", digits, 32'hFEDCBA98);
    check("t3_valid", {24'b0, valid}, 32'hFF);
    check("t3_err", {24'b0, err}, 32'h00);
    check_model("t3");

    // asynchronous reset in the middle of a scan slot
    hold(8'hFE, SEG_TAB[3], 2);
    #2;
    rst_n = 1'b0;
    an_r  = '1;
    hex_r = '1;
    #1;
    check("mrst_digits", digits, 32'd0);
    check("mrst_valid", {24'b0, valid}, 32'd0);
    check("mrst_err", {24'b0, err}, 32'd0);
    check("mrst_upd", {31'b0, upd}, 32'd0);
    check("mrst_state", {30'b0, dbg_state}, 32'd0);
    model_clear();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    hold(8'hFF, 7'h7F, 3);

    // short glitch of 3 then a held 8 on digit 3
    push_acc(3, SEG_TAB[8]);
    hold(8'hF7, SEG_TAB[3], 2);
    hold(8'hF7, SEG_TAB[8], 10);
    hold(8'hFF, 7'h7F, 5);
    check("t4_digits", digits, 32'h00008000);
    check("t4_valid", {24'b0, valid}, 32'h08);

    // ghosting, blank slots and a 3-cycle glitch are ignored
    for (int k = 0; k < 20; k++) hold(8'hFC, 7'($urandom_range(0, 127)), 1);
    for (int k = 0; k < 10; k++) hold(8'hFF, 7'($urandom_range(0, 127)), 1);
    hold(8'hDF, SEG_TAB[5], 3);
    hold(8'hFF, 7'h7F, 6);
    check_model("t5_ignore");

    // undecodable pattern on digit 2
    push_acc(2, 7'b1010101);
    hold(8'hFB, 7'b1010101, 8);
    hold(8'hFF, 7'h7F, 5);
    check("t5_err", {24'b0, err}, 32'h04);
    check("t5_valid", {24'b0, valid}, 32'h08);

    // random scan, hold lengths straddling the acceptance threshold
    prev_idx = -1;
    for (int k = 0; k < 16; k++) begin
      do r_idx = $urandom_range(0, 7); while (r_idx == prev_idx);
      prev_idx = r_idx;
      r_val = $urandom_range(0, 15);
      r_len = $urandom_range(3, 8);
      if (r_len >= 4) push_acc(r_idx, SEG_TAB[r_val]);
      hold(~(8'h01 << r_idx), SEG_TAB[r_val], r_len);
    end
    hold(8'hFF, 7'h7F, 10);
    check_model("rand");
    check("rand_drain", exp_q.size(), 32'd0);

    // clr on the same edge as an accept of digit 6
    model_clear();
    push_acc(6, SEG_TAB[5]);
    an_r  = 8'hBF;
    hex_r = SEG_TAB[5];
    repeat (5) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    hold(8'hBF, SEG_TAB[5], 3);
    hold(8'hFF, 7'h7F, 5);
    check("clr_acc_digits", digits, 32'h05000000);
    check("clr_acc_valid", {24'b0, valid}, 32'h40);
    check("clr_acc_err", {24'b0, err}, 32'h00);

    // blank pattern on digit 1, then clr
    push_acc(1, SEG_TAB[10]);
    hold(8'hFD, SEG_TAB[10], 6);
    push_acc(1, 7'b1111111);
    hold(8'hFD, 7'b1111111, 6);
    hold(8'hFF, 7'h7F, 5);
    check_model("t6");
`ifdef SEG7_DEC_BLANK_EN
    check("t6_err_blank", {24'b0, err}, 32'h00);
`else
    check("t6_err_blank", {24'b0, err}, 32'h02);
`endif
    check("t6_valid1", {31'b0, valid[1]}, 32'd0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_digits", digits, 32'd0);
    check("clr_valid", {24'b0, valid}, 32'd0);
    check("clr_err", {24'b0, err}, 32'd0);
    check("final_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
